// File: rtl/lfsr_arbiter_ctrl.sv
// lfsr_arbiter_ctrl: two-requester round-robin arbiter handing out 5-bit LFSR values, one per grant.
module lfsr_arbiter_ctrl #(
  parameter logic [4:0] SEED_DEFAULT = 5'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       seed_load,
  input  logic [4:0] seed_val,
  output logic [1:0] gnt,
  output logic [4:0] rnd_out,
  output logic       busy,
  output logic       wrap_pulse
);
  typedef enum logic [1:0] {IDLE, SERVE, LOAD} state_t;
  state_t state, state_d;
  logic sel, last_winner, win, fire;
  logic [4:0] lfsr_q, serve_cnt, seed_q;
  always_comb begin
    win = (req == 2'b10) | ((req == 2'b11) & ~last_winner);
    state_d = (state != IDLE) ? IDLE : seed_load ? LOAD : (|req) ? SERVE : IDLE;
    // reset low aborts a grant in flight, so outputs are gated by it
    fire = reset && (state == SERVE) && req[sel];
    gnt = fire ? (sel ? 2'b10 : 2'b01) : 2'b00;
    busy = reset && (state != IDLE);
    wrap_pulse = fire && (serve_cnt == 5'd30);
    rnd_out = lfsr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      lfsr_q <= SEED_DEFAULT;
      last_winner <= 1'b1;
      serve_cnt <= 5'd0;
      sel <= 1'b0;
      seed_q <= 5'd0;
    end else begin
      state <= state_d;
      if (state == IDLE && !seed_load && |req) sel <= win;
      if (state == IDLE && seed_load) seed_q <= seed_val;
      if (fire) begin
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2], lfsr_q[4:1]};
        last_winner <= sel;
        serve_cnt <= (serve_cnt == 5'd30) ? 5'd0 : serve_cnt + 5'd1;
      end
      if (state == LOAD) begin
        lfsr_q <= (seed_q == 5'd0) ? SEED_DEFAULT : seed_q;
        serve_cnt <= 5'd0;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_arbiter_ctrl.sv
// tb_lfsr_arbiter_ctrl: directed-vector bench for lfsr_arbiter_ctrl.
module tb_lfsr_arbiter_ctrl;
  logic clk = 1'b0;
  logic reset, seed_load, busy, wrap_pulse;
  logic [1:0] req, gnt;
  logic [4:0] seed_val, rnd_out;
  int total = 0;
  int passed = 0;
  lfsr_arbiter_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_val(seed_val),
    .gnt(gnt), .rnd_out(rnd_out), .busy(busy), .wrap_pulse(wrap_pulse)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  logic [4:0] exp_a [5] = '{5'h01, 5'h10, 5'h08, 5'h04, 5'h12};
  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  initial begin
    reset = 1'b0; req = 2'b00; seed_load = 1'b0; seed_val = 5'h00;
    tick(); tick();
    chk("rst_rnd", rnd_out, 5'h01);
    chk("rst_gnt", {3'b0, gnt}, 5'h00);
    chk("rst_busy", {4'b0, busy}, 5'h00);
    chk("rst_wrap", {4'b0, wrap_pulse}, 5'h00);
    reset = 1'b1; req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("single_gnt", {3'b0, gnt}, 5'h01);
      chk("single_rnd", rnd_out, exp_a[i]);
      chk("single_busy", {4'b0, busy}, 5'h01);
      tick(); #1;
      chk("single_gap", {3'b0, gnt}, 5'h00);
    end
    reset = 1'b0; req = 2'b00;
    tick(); tick();
    reset = 1'b1; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("rr_gnt", {3'b0, gnt}, {3'b0, exp_g[i]});
      chk("rr_rnd", rnd_out, exp_a[i]);
      tick(); #1;
      chk("rr_gap", {3'b0, gnt}, 5'h00);
    end
    req = 2'b00; seed_load = 1'b1; seed_val = 5'h00;
    tick(); #1;
    chk("load0_busy", {4'b0, busy}, 5'h01);
    chk("load0_gnt", {3'b0, gnt}, 5'h00);
    seed_load = 1'b0;
    tick(); req = 2'b01;
    tick(); #1;
    chk("seed0_gnt", {3'b0, gnt}, 5'h01);
    chk("seed0_rnd", rnd_out, 5'h01);
    tick();
    seed_load = 1'b1; seed_val = 5'h0A;
    tick(); #1;
    chk("loadA_prio_gnt", {3'b0, gnt}, 5'h00);
    chk("loadA_busy", {4'b0, busy}, 5'h01);
    seed_load = 1'b0; seed_val = 5'h1F;
    tick();
    tick(); #1;
    chk("seedA_rnd1", rnd_out, 5'h0A);
    tick();
    tick(); #1;
    chk("seedA_rnd2", rnd_out, 5'h05);
    seed_load = 1'b1; seed_val = 5'h03;
    tick(); #1;
    seed_load = 1'b0;
    chk("ign_busy", {4'b0, busy}, 5'h00);
    tick(); #1;
    chk("ign_rnd", rnd_out, 5'h02);
    reset = 1'b0; req = 2'b00;
    tick(); tick();
    reset = 1'b1; req = 2'b01;
    for (int i = 0; i < 32; i++) begin
      tick(); #1;
      chk("wrap_gnt", {3'b0, gnt}, 5'h01);
      chk("wrap_pulse", {4'b0, wrap_pulse}, (i == 30) ? 5'h01 : 5'h00);
      if (i == 31) chk("wrap_rnd32", rnd_out, 5'h01);
      tick();
    end
    tick(); req = 2'b00; #1;
    chk("wd_gnt", {3'b0, gnt}, 5'h00);
    chk("wd_rnd", rnd_out, 5'h10);
    tick(); #1;
    chk("wd_rnd_after", rnd_out, 5'h10);
    req = 2'b01;
    tick(); #1;
    chk("abort_pre_gnt", {3'b0, gnt}, 5'h01);
    reset = 1'b0; #1;
    chk("abort_gnt", {3'b0, gnt}, 5'h00);
    chk("abort_busy", {4'b0, busy}, 5'h00);
    tick(); #1;
    chk("abort_rnd", rnd_out, 5'h01);
    chk("abort_wrap", {4'b0, wrap_pulse}, 5'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
